// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode encodings and NZCV flag bit positions shared by the ALU and
//            the execute stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_NOP   = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_CMP   = 3'd6;
  localparam logic [2:0] ALU_SHIFT = 3'd7;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : 32-bit combinational ALU, 3-bit opcode, NZCV flag outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu
  import alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] dataOut,
  output logic        N,
  output logic        Z,
  output logic        C,
  output logic        V
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic [32:0] shl;
  logic [31:0] fval;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign shl  = {1'b0, a} << b[1:0];

  // CMP sets flags from a-b but produces no data; NOP produces neither.
  always_comb begin
    dataOut = '0;
    fval    = '0;
    C       = 1'b0;
    V       = 1'b0;
    case (op)
      ALU_ADD: begin
        dataOut = sum[31:0];
        fval    = sum[31:0];
        C       = sum[32];
        V       = ~(a[31] ^ b[31]) & (sum[31] ^ a[31]);
      end
      ALU_SUB: begin
        dataOut = diff[31:0];
        fval    = diff[31:0];
        C       = diff[32];
        V       = (a[31] ^ b[31]) & (diff[31] ^ a[31]);
      end
      ALU_AND: begin
        dataOut = a & b;
        fval    = a & b;
      end
      ALU_OR: begin
        dataOut = a | b;
        fval    = a | b;
      end
      ALU_XOR: begin
        dataOut = a ^ b;
        fval    = a ^ b;
      end
      ALU_CMP: begin
        fval = diff[31:0];
        C    = diff[32];
        V    = (a[31] ^ b[31]) & (diff[31] ^ a[31]);
      end
      ALU_SHIFT: begin
        dataOut = shl[31:0];
        fval    = shl[31:0];
        C       = shl[32];
      end
      default: ;
    endcase
    N = fval[31];
    Z = (op != ALU_NOP) && (fval == 32'd0);
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_fifo.sv
// ============================================================================
// Module   : alu_result_fifo
// Brief    : Circular result queue; head is zero while empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_stage.sv
// ============================================================================
// Module   : alu_exec_stage
// Brief    : Registered ALU execute stage with result queue and NZCV status.
//            Define ALU_EXEC_FWD_EN to forward the previous result onto A/B.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_setflags,
  input  logic             in_fwd_a,
  input  logic             in_fwd_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic [3:0]       status_nzcv
);

  localparam int ENT_W = 32 + TAG_W + 4;

  logic             op_valid_q, op_valid_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             setflags_q, setflags_d;
  logic [3:0]       status_q, status_d;

  logic             accept, advance, pop, q_full, q_empty;
  logic [31:0]      bus_a, bus_b, alu_data;
  logic             alu_n, alu_z, alu_c, alu_v;
  logic [3:0]       alu_flags;
  logic [ENT_W-1:0] head;

  assign pop       = out_valid & out_ready;
  assign advance   = op_valid_q & (~q_full | pop);
  assign in_ready  = ~op_valid_q | advance;
  assign accept    = in_valid & in_ready;
  assign alu_flags = pack_nzcv(alu_n, alu_z, alu_c, alu_v);

`ifdef ALU_EXEC_FWD_EN
  logic        fwd_a_q, fwd_a_d;
  logic        fwd_b_q, fwd_b_d;
  logic [31:0] last_result_q, last_result_d;

  // Every advancing op, NOP included, becomes the next forwarding source.
  always_comb begin
    fwd_a_d       = fwd_a_q;
    fwd_b_d       = fwd_b_q;
    last_result_d = last_result_q;
    if (accept) begin
      fwd_a_d = in_fwd_a;
      fwd_b_d = in_fwd_b;
    end
    if (advance) begin
      last_result_d = alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q       <= 1'b0;
      fwd_b_q       <= 1'b0;
      last_result_q <= '0;
    end else begin
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      last_result_q <= last_result_d;
    end
  end

  assign bus_a = fwd_a_q ? last_result_q : a_q;
  assign bus_b = fwd_b_q ? last_result_q : b_q;
`else
  logic unused_fwd;
  assign unused_fwd = in_fwd_a ^ in_fwd_b;
  assign bus_a      = a_q;
  assign bus_b      = b_q;
`endif

  always_comb begin
    op_valid_d = op_valid_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    setflags_d = setflags_q;
    status_d   = status_q;
    if (advance) begin
      op_valid_d = 1'b0;
      if (setflags_q && (op_q != ALU_NOP)) begin
        status_d = alu_flags;
      end
    end
    if (accept) begin
      op_valid_d = 1'b1;
      op_d       = in_op;
      a_d        = in_a;
      b_d        = in_b;
      tag_d      = in_tag;
      setflags_d = in_setflags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      setflags_q <= 1'b0;
      status_q   <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      setflags_q <= setflags_d;
      status_q   <= status_d;
    end
  end

  alu u_alu (
    .op      (op_q),
    .a       (bus_a),
    .b       (bus_b),
    .dataOut (alu_data),
    .N       (alu_n),
    .Z       (alu_z),
    .C       (alu_c),
    .V       (alu_v)
  );

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (advance),
    .push_data ({alu_data, tag_q, alu_flags}),
    .pop       (pop),
    .head_data (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign out_valid   = ~q_empty;
  assign out_data    = head[ENT_W-1 -: 32];
  assign out_tag     = head[4 +: TAG_W];
  assign out_flags   = head[3:0];
  assign status_nzcv = status_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
// Module   : tb_alu_exec_stage
// Brief    : Scoreboard bench for alu_exec_stage (DEPTH=2, TAG_W=5).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
    logic [3:0]  flags;
  } ent_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        in_setflags, in_fwd_a, in_fwd_b;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [3:0]  out_flags;
  logic [3:0]  status_nzcv;

  ent_t        exp_q[$];
  ent_t        obs_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_last = '0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DEPTH(2), .TAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .in_setflags (in_setflags),
    .in_fwd_a    (in_fwd_a),
    .in_fwd_b    (in_fwd_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_flags   (out_flags),
    .status_nzcv (status_nzcv)
  );

  // Reference behaviour: flags {N,Z,C,V}, C on subtract means "no borrow".
  function automatic ent_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag, input logic fa, input logic fb);
    logic [31:0] x, y, r;
    logic [63:0] u;
    logic        n, z, c, v;
    longint      s;
    int          sh;
    ent_t        e;
    x = a;
    y = b;
`ifdef ALU_EXEC_FWD_EN
    if (fa) x = model_last;
    if (fb) y = model_last;
`else
    if (fa || fb) x = a;
`endif
    r = '0; n = 0; z = 0; c = 0; v = 0;
    case (op)
      3'd1: begin
        u = {32'd0, x} + {32'd0, y};
        r = u[31:0];
        c = u[32];
        s = longint'($signed(x)) + longint'($signed(y));
        v = (s > SMAX) || (s < SMIN);
      end
      3'd2, 3'd6: begin
        r = x - y;
        c = (x >= y);
        s = longint'($signed(x)) - longint'($signed(y));
        v = (s > SMAX) || (s < SMIN);
      end
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd7: begin
        sh = int'(y[1:0]);
        r  = x << sh;
        c  = (sh == 0) ? 1'b0 : x[32-sh];
      end
      default: r = '0;
    endcase
    if (op != 3'd0) begin
      n = r[31];
      z = (r == 32'd0);
    end
    if (op == 3'd6) r = '0;
    e.data  = r;
    e.tag   = tag;
    e.flags = {n, z, c, v};
    return e;
  endfunction

  // One clock: settle after negedge, log handshakes, then return at the next negedge.
  task automatic cycle(output bit acc);
    ent_t e;
    #1;
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    if (acc) begin
      e = model(in_op, in_a, in_b, in_tag, in_fwd_a, in_fwd_b);
      exp_q.push_back(e);
      model_last = e.data;
    end
    if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
      obs_q.push_back({out_data, out_tag, out_flags});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic sf, input logic fa, input logic fb);
    in_valid    = 1'b1;
    in_op       = op;
    in_a        = a;
    in_b        = b;
    in_tag      = tag;
    in_setflags = sf;
    in_fwd_a    = fa;
    in_fwd_b    = fb;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic sf, input logic fa, input logic fb);
    bit acc;
    int n;
    drive(op, a, b, tag, sf, fa, fb);
    acc = 0;
    n   = 0;
    while (!acc && n < 50) begin
      cycle(acc);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag=%0d not accepted within 50 cycles", tag);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 40) begin
      cycle(acc);
      n++;
    end
    if (obs_q.size() < exp_q.size()) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d results, need %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready got %b need 1", in_ready); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid got %b need 0", out_valid); end
    checks++; if (out_data !== 32'd0)   begin errors++; $display("FAIL rst_out_data got %h need 0", out_data); end
    checks++; if (out_tag !== 5'd0)     begin errors++; $display("FAIL rst_out_tag got %h need 0", out_tag); end
    checks++; if (out_flags !== 4'd0)   begin errors++; $display("FAIL rst_out_flags got %b need 0", out_flags); end
    checks++; if (status_nzcv !== 4'd0) begin errors++; $display("FAIL rst_status got %b need 0", status_nzcv); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    bit   acc;
    ent_t e, o;
    out_ready = 1'b0;
    drive(3'd1, 32'h7FFF_FFFF, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
    cycle(acc);
    in_valid = 1'b0;
    checks++; if (!acc) begin errors++; $display("FAIL add_accept got %b need 1", acc); end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early got out_valid=%b need 0", out_valid); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1)          begin errors++; $display("FAIL add_valid got %b need 1", out_valid); end
    checks++; if (out_data !== 32'h8000_0000)  begin errors++; $display("FAIL add_data got %h need 80000000", out_data); end
    checks++; if (out_flags !== 4'b1001)       begin errors++; $display("FAIL add_flags got %b need 1001", out_flags); end
    checks++; if (status_nzcv !== 4'b1001)     begin errors++; $display("FAIL add_status got %b need 1001", status_nzcv); end
    @(negedge clk);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL add_sb missing tag=%0d", e.tag); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL add_sb got %h need %h", o, e); end
      end
    end
  endtask

  task automatic test_sub_noflags();
    bit   acc;
    ent_t e, o;
    out_ready = 1'b0;
    send(3'd2, 32'd5, 32'd5, 5'd2, 1'b0, 1'b0, 1'b0);
    cycle(acc);
    #1;
    checks++; if (out_valid !== 1'b1)      begin errors++; $display("FAIL sub_valid got %b need 1", out_valid); end
    checks++; if (out_data !== 32'd0)      begin errors++; $display("FAIL sub_data got %h need 0", out_data); end
    checks++; if (out_flags[2] !== 1'b1 || out_flags[3] !== 1'b0)
                                           begin errors++; $display("FAIL sub_flags got %b need N=0 Z=1", out_flags); end
    checks++; if (status_nzcv !== 4'b1001) begin errors++; $display("FAIL sub_status got %b need 1001", status_nzcv); end
    @(negedge clk);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL sub_sb missing tag=%0d", e.tag); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL sub_sb got %h need %h", o, e); end
      end
    end
  endtask

  task automatic test_stall_order();
    bit   acc;
    ent_t e, o;
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive(3'd1, 32'(t), 32'd100, 5'(t), 1'b0, 1'b0, 1'b0);
      cycle(acc);
      checks++; if (!acc) begin errors++; $display("FAIL stall_fill tag=%0d got accepted=%b need 1", t, acc); end
    end
    drive(3'd1, 32'd4, 32'd100, 5'd4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cycle(acc);
      checks++; if (acc) begin errors++; $display("FAIL stall_hold got accepted=%b need 0", acc); end
    end
    out_ready = 1'b1;
    cycle(acc);
    checks++; if (!acc) begin errors++; $display("FAIL stall_accept_with_pop got %b need 1", acc); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL stall_first_pop got %0d pops need 1", obs_q.size()); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_count got in_ready=%b need 0", in_ready); end
    checks++; if (out_tag !== 5'd2)  begin errors++; $display("FAIL full_head got tag=%0d need 2", out_tag); end
    @(negedge clk);
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL stall_sb missing tag=%0d", e.tag); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL stall_sb got %h need %h", o, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit         acc;
    ent_t       e, o;
    logic [2:0] ops [8];
    ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], $urandom, $urandom, 5'(i + 8), 1'b1, 1'b0, 1'b0);
      cycle(acc);
      checks++; if (!acc) begin errors++; $display("FAIL stream_ready op=%0d got accepted=%b need 1", i, acc); end
    end
    in_valid = 1'b0;
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL stream_rate got %0d results need 6", obs_q.size()); end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL stream_sb missing tag=%0d", e.tag); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL stream_sb got %h need %h", o, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   acc;
    ent_t e, o;
    out_ready = 1'b0;
    send(3'd1, 32'hFFFF_FFFF, 32'd1, 5'd20, 1'b1, 1'b0, 1'b0);
    send(3'd1, 32'd1, 32'd1, 5'd21, 1'b0, 1'b0, 1'b0);
    cycle(acc);
    #1;
    checks++; if (status_nzcv !== 4'b0110) begin errors++; $display("FAIL mid_status_pre got %b need 0110", status_nzcv); end
    checks++; if (out_valid !== 1'b1)      begin errors++; $display("FAIL mid_valid_pre got %b need 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL mid_rst_valid got %b need 0", out_valid); end
    checks++; if (status_nzcv !== 4'd0) begin errors++; $display("FAIL mid_rst_status got %b need 0", status_nzcv); end
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL mid_rst_ready got %b need 1", in_ready); end
    exp_q.delete();
    obs_q.delete();
    model_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(3'd2, 32'd3, 32'd5, 5'd22, 1'b1, 1'b0, 1'b0);
    drain();
    #1;
    checks++; if (status_nzcv !== 4'b1000) begin errors++; $display("FAIL mid_post_status got %b need 1000", status_nzcv); end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL mid_sb missing tag=%0d", e.tag); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL mid_sb got %h need %h", o, e); end
      end
    end
  endtask

  task automatic test_forward();
    ent_t        e, o;
    logic [31:0] want2;
`ifdef ALU_EXEC_FWD_EN
    want2 = 32'd13;
`else
    want2 = 32'd10;
`endif
    out_ready = 1'b1;
    send(3'd1, 32'd1, 32'd2, 5'd24, 1'b0, 1'b0, 1'b0);
    send(3'd1, 32'd0, 32'd10, 5'd25, 1'b0, 1'b1, 1'b0);
    drain();
    checks++;
    if (obs_q.size() < 2) begin errors++; $display("FAIL fwd_count got %0d need 2", obs_q.size()); end
    else begin
      if (obs_q[0].data !== 32'd3) begin errors++; $display("FAIL fwd_first got %0d need 3", obs_q[0].data); end
      checks++;
      if (obs_q[1].data !== want2) begin errors++; $display("FAIL fwd_second got %0d need %0d", obs_q[1].data, want2); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL fwd_sb missing tag=%0d", e.tag); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL fwd_sb got %h need %h", o, e); end
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_op       = '0;
    in_a        = '0;
    in_b        = '0;
    in_tag      = '0;
    in_setflags = 1'b0;
    in_fwd_a    = 1'b0;
    in_fwd_b    = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_overflow();
    test_sub_noflags();
    test_stall_order();
    test_back_to_back();
    test_reset_mid();
    test_forward();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
